// File: rtl/diagv2_mem_arbiter_if.sv
// Bus bundle between fetch/LSU requesters, the arbiter and the memory model.
// Latency: none (wires only).
// Backpressure: carried by gnt and mem_ready; rvalid pulses cannot be stalled.
interface diagv2_mem_arbiter_if #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
);
  logic               if_req;
  logic [ADDR_W-1:0]  if_addr;
  logic               if_gnt;
  logic               if_rvalid;
  logic [INSTR_W-1:0] if_rdata;
  logic               if_err;

  logic               d_req;
  logic               d_we;
  logic [ADDR_W-1:0]  d_addr;
  logic [DATA_W-1:0]  d_wdata;
  logic [2:0]         d_type;
  logic               d_gnt;
  logic               d_rvalid;
  logic [DATA_W-1:0]  d_rdata;
  logic               d_err;

  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [2:0]         mem_type;
  logic               mem_ready;
  logic               mem_rvalid;
  logic [DATA_W-1:0]  mem_rdata;

  logic               busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_type,
    input  mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_type,
    output busy
  );

  // Requester / memory-model side.
  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_type,
    output mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_type,
    input  busy
  );
endinterface

// File: rtl/diagv2_mem_arbiter.sv
// Shares one single-port memory between fetch and load/store, one transaction in flight.
// Latency: grant cycle 0, mem_req cycle 1, rvalid cycle 2 with zero-wait memory; next grant >= cycle 3.
// Backpressure: gnt only in IDLE; mem_req held until mem_ready. DIAGV2_ARB_MISALIGN_EN enables alignment errors.
module diagv2_mem_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int INSTR_W    = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  diagv2_mem_arbiter_if.slave  bus
);
  localparam int               CNT_W      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [2:0]       FETCH_TYPE = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   starve_cnt;
  logic               own_d;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [2:0]         lat_type;
  logic [INSTR_W-1:0] if_rdata_q;
  logic [DATA_W-1:0]  d_rdata_q;

  logic idle;
  logic grant_d;
  logic grant_i;
  logic misalign;
  logic load_done;
  logic store_done;

  // Data wins conflicts until fetch has lost STARVE_MAX in a row.
  assign idle    = (state == IDLE);
  assign grant_d = idle & bus.d_req & ~(bus.if_req & (starve_cnt == STARVE_LIM));
  assign grant_i = idle & bus.if_req & ~grant_d;

`ifdef DIAGV2_ARB_MISALIGN_EN
  logic d_misalign;
  logic if_misalign;
  logic err_q;

  // Alignment of the incoming requests against their access size.
  always_comb begin
    d_misalign = 1'b0;
    case (bus.d_type[1:0])
      2'd1:    d_misalign = bus.d_addr[0];
      2'd2:    d_misalign = |bus.d_addr[1:0];
      2'd3:    d_misalign = |bus.d_addr[2:0];
      default: d_misalign = 1'b0;
    endcase
    if_misalign = |bus.if_addr[1:0];
  end

  assign misalign = (grant_d & d_misalign) | (grant_i & if_misalign);

  // Error flag is decided on the way into RESP and only shown with rvalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_nxt == RESP) begin
      err_q <= misalign;
    end
  end

  assign bus.if_err = bus.if_rvalid & err_q;
  assign bus.d_err  = bus.d_rvalid & err_q;
`else
  assign misalign   = 1'b0;
  assign bus.if_err = 1'b0;
  assign bus.d_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and response-capture strobes.
  always_comb begin
    state_nxt  = state;
    load_done  = 1'b0;
    store_done = 1'b0;
    case (state)
      IDLE: begin
        if (grant_d | grant_i) begin
          state_nxt = misalign ? RESP : REQ;
        end
      end
      REQ: begin
        if (bus.mem_ready) begin
          if (lat_we) begin
            store_done = 1'b1;
            state_nxt  = RESP;
          end else if (bus.mem_rvalid) begin
            load_done = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          load_done = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, starvation counter and response data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_d      <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_type   <= '0;
      starve_cnt <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_d | grant_i) begin
        own_d     <= grant_d;
        lat_we    <= grant_d & bus.d_we;
        lat_addr  <= grant_d ? bus.d_addr : bus.if_addr;
        lat_wdata <= grant_d ? bus.d_wdata : '0;
        lat_type  <= grant_d ? bus.d_type : FETCH_TYPE;
      end

      if (grant_i) begin
        starve_cnt <= '0;
      end else if (grant_d & bus.if_req) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (load_done) begin
        if (own_d) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          if_rdata_q <= lat_addr[2] ? bus.mem_rdata[INSTR_W +: INSTR_W]
                                    : bus.mem_rdata[INSTR_W-1:0];
        end
      end else if (store_done) begin
        d_rdata_q <= '0;
      end else if (misalign) begin
        if (grant_d) begin
          d_rdata_q <= '0;
        end else begin
          if_rdata_q <= '0;
        end
      end
    end
  end

  assign bus.if_gnt    = grant_i;
  assign bus.d_gnt     = grant_d;
  assign bus.mem_req   = (state == REQ);
  assign bus.mem_we    = lat_we;
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.mem_type  = lat_type;
  assign bus.busy      = ~idle;
  assign bus.if_rvalid = (state == RESP) & ~own_d;
  assign bus.d_rvalid  = (state == RESP) & own_d;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_diagv2_mem_arbiter.sv
// Directed bench for diagv2_mem_arbiter with a response scoreboard.
// Inputs change on the falling edge; checks sample 1 time unit later.
// Build with +define+DIAGV2_ARB_MISALIGN_EN to cover the alignment checker.
module tb_diagv2_mem_arbiter;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  diagv2_mem_arbiter_if bus();

  diagv2_mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        is_d;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push(input logic is_d, input logic [63:0] data, input logic err);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_if_gnt"},    64'(bus.if_gnt),    64'd0);
    chk({pfx, "_d_gnt"},     64'(bus.d_gnt),     64'd0);
    chk({pfx, "_if_rvalid"}, 64'(bus.if_rvalid), 64'd0);
    chk({pfx, "_d_rvalid"},  64'(bus.d_rvalid),  64'd0);
    chk({pfx, "_if_rdata"},  64'(bus.if_rdata),  64'd0);
    chk({pfx, "_d_rdata"},   bus.d_rdata,        64'd0);
    chk({pfx, "_if_err"},    64'(bus.if_err),    64'd0);
    chk({pfx, "_d_err"},     64'(bus.d_err),     64'd0);
    chk({pfx, "_mem_req"},   64'(bus.mem_req),   64'd0);
    chk({pfx, "_mem_we"},    64'(bus.mem_we),    64'd0);
    chk({pfx, "_mem_addr"},  bus.mem_addr,       64'd0);
    chk({pfx, "_mem_wdata"}, bus.mem_wdata,      64'd0);
    chk({pfx, "_mem_type"},  64'(bus.mem_type),  64'd0);
    chk({pfx, "_busy"},      64'(bus.busy),      64'd0);
  endtask

  // Response monitor: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && (bus.if_rvalid || bus.d_rvalid)) begin
      chk("rvalid_expected", 64'(exp_q.size() != 0), 64'd1);
      chk("both_rvalid", 64'(bus.if_rvalid & bus.d_rvalid), 64'd0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rvalid_port", 64'(bus.d_rvalid), 64'(mon_e.is_d));
        chk("rdata", mon_e.is_d ? bus.d_rdata : 64'(bus.if_rdata), mon_e.data);
        chk("err", 64'(mon_e.is_d ? bus.d_err : bus.if_err), 64'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  pat;
    logic [63:0] rd;

    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_type = 0;
    bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    // Reset state
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("rst0");
    @(negedge clk);
    reset = 1'b1;

    // Fetch, zero-wait memory, upper word
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 64'h1004;
    #1;
    chk("f0_if_gnt", 64'(bus.if_gnt), 64'd1);
    chk("f0_d_gnt",  64'(bus.d_gnt),  64'd0);
    push(1'b0, 64'h11223344, 1'b0);
    @(negedge clk);
    bus.if_req = 0; bus.if_addr = 64'hFFF0;
    bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h11223344_55667788;
    #1;
    chk("f0_mem_req",   64'(bus.mem_req),  64'd1);
    chk("f0_mem_addr",  bus.mem_addr,      64'h1004);
    chk("f0_mem_type",  64'(bus.mem_type), 64'd2);
    chk("f0_mem_we",    64'(bus.mem_we),   64'd0);
    // RESP: a new request must not be granted here
    @(negedge clk);
    bus.mem_ready = 0; bus.mem_rvalid = 0;
    bus.if_req = 1; bus.if_addr = 64'h1000;
    #1;
    chk("f0_resp_if_rvalid", 64'(bus.if_rvalid), 64'd1);
    chk("f0_resp_no_gnt",    64'(bus.if_gnt),    64'd0);
    chk("f0_resp_mem_req",   64'(bus.mem_req),   64'd0);
    // Cycle 3: earliest next grant, lower word
    @(negedge clk);
    #1;
    chk("f1_if_gnt", 64'(bus.if_gnt), 64'd1);
    push(1'b0, 64'h55667788, 1'b0);
    @(negedge clk);
    bus.if_req = 0;
    bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h11223344_55667788;
    #1;
    chk("f1_mem_addr", bus.mem_addr, 64'h1000);
    @(negedge clk);
    bus.mem_ready = 0; bus.mem_rvalid = 0;

    // Store with three stall cycles
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h200; bus.d_wdata = 64'hDEADBEEF; bus.d_type = 3;
    #1;
    chk("st_d_gnt",  64'(bus.d_gnt),  64'd1);
    chk("st_if_gnt", 64'(bus.if_gnt), 64'd0);
    push(1'b1, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 64'h999; bus.d_wdata = 0; bus.d_type = 0;
      bus.mem_ready = (i == 3);
      #1;
      chk($sformatf("st_mem_req_%0d", i),   64'(bus.mem_req),  64'd1);
      chk($sformatf("st_mem_addr_%0d", i),  bus.mem_addr,      64'h200);
      chk($sformatf("st_mem_wdata_%0d", i), bus.mem_wdata,     64'hDEADBEEF);
      chk($sformatf("st_mem_we_%0d", i),    64'(bus.mem_we),   64'd1);
      chk($sformatf("st_mem_type_%0d", i),  64'(bus.mem_type), 64'd3);
    end
    @(negedge clk);
    bus.mem_ready = 0;
    #1;
    chk("st_resp_d_rvalid", 64'(bus.d_rvalid), 64'd1);
    chk("st_resp_mem_req",  64'(bus.mem_req),  64'd0);

    // Starvation limit: both requesters held high
    pat = 10'b1000010000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.if_req = 1; bus.if_addr = 64'h2000;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h400; bus.d_type = 3;
      #1;
      chk($sformatf("sv_if_gnt_%0d", i), 64'(bus.if_gnt), 64'(pat[i]));
      chk($sformatf("sv_d_gnt_%0d", i),  64'(bus.d_gnt),  64'(!pat[i]));
      rd = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
      if (pat[i]) push(1'b0, {32'd0, rd[31:0]}, 1'b0);
      else        push(1'b1, rd, 1'b0);
      @(negedge clk);
      bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = rd;
      @(negedge clk);
      bus.mem_ready = 0; bus.mem_rvalid = 0;
    end
    bus.if_req = 0; bus.d_req = 0;

    // Load with delayed response
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h300; bus.d_type = 3;
    #1;
    chk("ld_d_gnt", 64'(bus.d_gnt), 64'd1);
    push(1'b1, 64'h01234567_89ABCDEF, 1'b0);
    @(negedge clk);
    bus.d_req = 0; bus.mem_ready = 1; bus.mem_rvalid = 0;
    #1;
    chk("ld_mem_req", 64'(bus.mem_req), 64'd1);
    @(negedge clk);
    bus.mem_ready = 0;
    #1;
    chk("ld_wait_mem_req", 64'(bus.mem_req), 64'd0);
    chk("ld_wait_busy",    64'(bus.busy),    64'd1);
    @(negedge clk);
    bus.mem_rvalid = 1; bus.mem_rdata = 64'h01234567_89ABCDEF;
    #1;
    chk("ld_wait2_d_rvalid", 64'(bus.d_rvalid), 64'd0);
    @(negedge clk);
    bus.mem_rvalid = 0;
    #1;
    chk("ld_resp_d_rvalid", 64'(bus.d_rvalid), 64'd1);
    // Stray mem_rvalid in IDLE is ignored; rdata holds
    @(negedge clk);
    bus.mem_rvalid = 1; bus.mem_rdata = 64'hBAD0BAD0;
    #1;
    chk("ld_one_pulse",  64'(bus.d_rvalid), 64'd0);
    chk("ld_rdata_hold", bus.d_rdata,       64'h01234567_89ABCDEF);
    chk("ld_idle_busy",  64'(bus.busy),     64'd0);
    @(negedge clk);
    bus.mem_rvalid = 0;
    #1;
    chk("ld_stray_busy",  64'(bus.busy),    64'd0);
    chk("ld_stray_rdata", bus.d_rdata,      64'h01234567_89ABCDEF);

    // Word access at 0x102
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h102; bus.d_type = 2;
    #1;
    chk("ma_d_gnt", 64'(bus.d_gnt), 64'd1);
`ifdef DIAGV2_ARB_MISALIGN_EN
    push(1'b1, 64'd0, 1'b1);
    @(negedge clk);
    bus.d_req = 0;
    #1;
    chk("ma_no_mem_req", 64'(bus.mem_req),  64'd0);
    chk("ma_d_rvalid",   64'(bus.d_rvalid), 64'd1);
    // Misaligned fetch
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 64'h1002;
    #1;
    chk("mf_if_gnt", 64'(bus.if_gnt), 64'd1);
    push(1'b0, 64'd0, 1'b1);
    @(negedge clk);
    bus.if_req = 0;
    #1;
    chk("mf_no_mem_req", 64'(bus.mem_req),   64'd0);
    chk("mf_if_rvalid",  64'(bus.if_rvalid), 64'd1);
`else
    push(1'b1, 64'h0000_0000_CAFE_F00D, 1'b0);
    @(negedge clk);
    bus.d_req = 0;
    bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h0000_0000_CAFE_F00D;
    #1;
    chk("ma_mem_req",  64'(bus.mem_req), 64'd1);
    chk("ma_mem_addr", bus.mem_addr,     64'h102);
    @(negedge clk);
    bus.mem_ready = 0; bus.mem_rvalid = 0;
`endif

    // Reset in the middle of WAIT
    @(negedge clk);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h100; bus.d_type = 3;
    #1;
    chk("rw_d_gnt", 64'(bus.d_gnt), 64'd1);
    @(negedge clk);
    bus.d_req = 0; bus.mem_ready = 1; bus.mem_rvalid = 0;
    @(negedge clk);
    bus.mem_ready = 0;
    #1;
    chk("rw_wait_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1 check_all_zero("rw_in_reset");
    @(negedge clk);
    reset = 1'b1;
    bus.mem_rvalid = 1; bus.mem_rdata = 64'hAA;
    #1;
    chk("rw_late_busy",     64'(bus.busy),     64'd0);
    chk("rw_late_d_rvalid", 64'(bus.d_rvalid), 64'd0);
    @(negedge clk);
    bus.mem_rvalid = 0;
    #1 check_all_zero("rw_after1");
    @(negedge clk);
    #1 check_all_zero("rw_after2");

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/diagv2_mem_arbiter.md
Name: diagv2_mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store port.
- Arbitrates between the two requesters, sequences the memory handshake, and returns read data or write acknowledgements.
- Allows exactly one outstanding transaction.
- Sits between the pipeline's fetch/LSU logic and the external memory model.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, memory data width.
- INSTR_W, 32, instruction width returned to fetch.
- STARVE_MAX, 4, maximum consecutive conflict rounds fetch may lose to data; 0 means fetch wins every conflict.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted (combinational, IDLE only).
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  INSTR_W  fetched instruction.
- if_err  out  1  fetch error, qualified by if_rvalid.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_type  in  3  [1:0] size (0=B, 1=H, 2=W, 3=D); [2] unsigned; passed through unmodified.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  out  DATA_W  load data (0 for stores).
- d_err  out  1  data error, qualified by d_rvalid.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_type  out  3  access type; fetch issues 3'b010.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; starvation counter cleared.
  - All outputs and latched request fields are 0.
  - Any in-flight memory response is abandoned.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If either request is high, grant exactly one requester (gnt high in the same cycle).
  - Latch addr, we, wdata and type, plus the owner; go to REQ.
  - With no request, stay in IDLE.
- Arbitration on conflict (both requests high):
  - Data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - starve_cnt increments when data wins a conflict.
  - starve_cnt clears when fetch is granted.
  - starve_cnt is unchanged when only one requester is present.
- REQ:
  - mem_req=1 and mem_* fields driven from the latch, held stable until mem_ready.
  - On mem_ready with a store: go to RESP.
  - On mem_ready with a load, mem_rvalid also 1: capture data, go to RESP.
  - On mem_ready with a load, mem_rvalid 0: go to WAIT.
  - mem_req deasserts the cycle after the mem_ready handshake.
- WAIT: on mem_rvalid, capture mem_rdata and go to RESP.
- RESP:
  - Pulse the owner's rvalid for one cycle; go to IDLE.
  - No grant is issued in RESP.
- Fetch data: if_rdata = mem_rdata[63:32] when latched if_addr[2]=1, else mem_rdata[31:0].
- Store ack: d_rdata=0 with d_rvalid.
- rdata holds its value until the next rvalid.
- mem_rvalid outside REQ/WAIT is ignored.
- Requesters may drop req after gnt; any req change during REQ/WAIT/RESP is ignored.
- Latency (zero-wait memory):
  - Grant at cycle 0, mem_req at cycle 1, rvalid at cycle 2.
  - Next grant no earlier than cycle 3.
- Without the optional feature: if_err=d_err=0 always.

Optional Feature:
- Macro: DIAGV2_ARB_MISALIGN_EN.
- Defined:
  - A granted fetch is misaligned when if_addr[1:0]!=0.
  - A granted data access is misaligned when the address is not a multiple of the d_type size.
  - A misaligned access still receives gnt, but IDLE goes directly to RESP with no mem_req.
  - RESP pulses rvalid with err=1 and rdata=0; starvation rules are unchanged.
- Undefined:
  - No alignment check; all accesses are issued to memory.
  - err outputs are tied to 0.

Test Plan:
- Reset mid-WAIT:
  - Stimulus: d load to 0x100 reaches WAIT, then assert reset=0; afterwards return mem_rvalid=1 with mem_rdata=0xAA.
  - Response: FSM in IDLE, no d_rvalid, busy=0, all outputs 0.
- Fetch, zero-wait memory:
  - Stimulus: if_req with if_addr=0x1004; mem_ready and mem_rvalid both 1 in the REQ cycle, mem_rdata=0x11223344_55667788.
  - Response: if_gnt at cycle 0, mem_req at cycle 1, if_rvalid at cycle 2 with if_rdata=0x11223344.
- Store with stall:
  - Stimulus: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_type=3; mem_ready held low for 3 cycles.
  - Response: mem_req and mem_* fields stable for 4 cycles, then d_rvalid pulse with d_rdata=0 and d_err=0.
- Starvation limit:
  - Stimulus: if_req and d_req held high continuously, STARVE_MAX=4.
  - Response: grant order D,D,D,D,I,D,D,D,D,I.
- Load with delayed response:
  - Stimulus: mem_ready in REQ, mem_rvalid 2 cycles later with mem_rdata=0x0123456789ABCDEF.
  - Response: d_rvalid one cycle after mem_rvalid with d_rdata=0x0123456789ABCDEF; exactly one pulse.
- Misaligned access (DIAGV2_ARB_MISALIGN_EN defined):
  - Stimulus: d_type=2 with d_addr=0x102.
  - Response: d_gnt, no mem_req, d_rvalid with d_err=1 one cycle later.
